// File: rtl/hazard_ctrl_if.sv
// Hazard controller pipeline-side bundle: ID/EX hazard inputs, mul/div
// handshake, stall/flush controls and performance counters.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);

  logic [REG_ADDR_W-1:0] rs1_ID;
  logic [REG_ADDR_W-1:0] rs2_ID;
  logic                  use_rs1_ID;
  logic                  use_rs2_ID;
  logic [REG_ADDR_W-1:0] rd_EX;
  logic                  MemRead_EX;
  logic                  redirect_EX;
  logic                  md_valid_EX;
  logic                  md_done;
  logic                  md_start;
  logic                  pc_stall;
  logic                  if_id_stall;
  logic                  if_id_flush;
  logic                  id_ex_stall;
  logic                  id_ex_flush;
  logic                  ex_mem_bubble;
  logic                  md_timeout;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  // Pipeline / mul-div side: supplies hazard inputs, consumes controls.
  modport master (
    output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, MemRead_EX,
           redirect_EX, md_valid_EX, md_done,
    input  md_start, pc_stall, if_id_stall, if_id_flush, id_ex_stall,
           id_ex_flush, ex_mem_bubble, md_timeout, stall_cnt, flush_cnt
  );

  // Hazard controller side.
  modport slave (
    input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, MemRead_EX,
           redirect_EX, md_valid_EX, md_done,
    output md_start, pc_stall, if_id_stall, if_id_flush, id_ex_stall,
           id_ex_flush, ex_mem_bubble, md_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use stalls,
// branch/jump redirect flushes, mul/div sequencing with timeout, and
// saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int TMR_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_RUN,
    S_MD_BUSY
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;
  logic [TMR_W-1:0]      timer;
  logic [CNT_W-1:0]      stall_q;
  logic [CNT_W-1:0]      flush_q;
  logic                  md_start_q;
  logic                  md_timeout_q;

  logic load_use;
  logic redirect_take;
  logic md_enter;
  logic md_expire;

  logic pc_stall;
  logic if_id_stall;
  logic if_id_flush;
  logic id_ex_stall;
  logic id_ex_flush;
  logic ex_mem_bubble;

  assign rs1 = hz.rs1_ID;
  assign rs2 = hz.rs2_ID;
  assign rd  = hz.rd_EX;

  // x0 is never a real dependency, so a load to x0 never stalls.
  assign load_use = hz.MemRead_EX & (rd != '0) &
                    ((hz.use_rs1_ID & (rs1 == rd)) |
                     (hz.use_rs2_ID & (rs2 == rd)));

  // Redirect outranks a mul/div in EX: the squashed path must not start it.
  assign redirect_take = (state == S_RUN) & hz.redirect_EX;
  assign md_enter      = (state == S_RUN) & ~hz.redirect_EX & hz.md_valid_EX;

  // A done in the final allowed cycle still counts as completion.
  assign md_expire = (state == S_MD_BUSY) & ~hz.md_done & (timer == TMR_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RUN: begin
        if (md_enter) begin
          state_nxt = S_MD_BUSY;
        end
      end
      S_MD_BUSY: begin
        if (hz.md_done || md_expire) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Stall/flush controls, combinational so they act in the current cycle.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    unique case (state)
      S_RUN: begin
        if (hz.redirect_EX) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (hz.md_valid_EX) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      S_MD_BUSY: begin
        if (hz.md_done) begin
          // Result flows into EX/MEM this cycle; pipeline resumes.
        end else if (md_expire) begin
          // Op dropped: release the pipeline but keep EX/MEM empty.
          ex_mem_bubble = 1'b1;
        end else begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Busy-cycle timer, restarted on every entry into S_MD_BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (md_enter) begin
      timer <= '0;
    end else if (state == S_MD_BUSY) begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Single-cycle start pulse issued on the edge that enters S_MD_BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_start_q <= 1'b0;
    end else begin
      md_start_q <= md_enter;
    end
  end

  // Sticky timeout error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_timeout_q <= 1'b0;
    end else if (md_expire) begin
      md_timeout_q <= 1'b1;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (pc_stall && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  // Saturating redirect-event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= '0;
    end else if (redirect_take && (flush_q != '1)) begin
      flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.md_start      = md_start_q;
  assign hz.pc_stall      = pc_stall;
  assign hz.if_id_stall   = if_id_stall;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_stall   = id_ex_stall;
  assign hz.id_ex_flush   = id_ex_flush;
  assign hz.ex_mem_bubble = ex_mem_bubble;
  assign hz.md_timeout    = md_timeout_q;
  assign hz.stall_cnt     = stall_q;
  assign hz.flush_cnt     = flush_q;

endmodule
